// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared select encodings and width limit for the registered 2:1 mux
package mux_pkg;
    localparam logic MUX_SEL_A     = 1'b0;
    localparam logic MUX_SEL_B     = 1'b1;
    localparam int   MUX_MAX_WIDTH = 64;
endpackage

// File: rtl/mux_2to1_core.sv
// rtl/mux_2to1_core.sv - combinational WIDTH-bit 2:1 select built from gate primitives
module mux_2to1_core #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] m
);
    wire [WIDTH-1:0] m_w;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            wire sel_n;
            wire pick_a;
            wire pick_b;
            not u_inv   (sel_n, sel);
            and u_and_a (pick_a, a[i], sel_n);
            and u_and_b (pick_b, b[i], sel);
            or  u_or    (m_w[i], pick_a, pick_b);
        end
    endgenerate

    assign m = m_w;
endmodule

// File: rtl/mux_2to1.sv
// rtl/mux_2to1.sv - registered 2:1 mux with valid tracking; MUX_2TO1_HOLD_EN adds load enable en
module mux_2to1
    import mux_pkg::*;
#(
    parameter int                       WIDTH   = 1,
    parameter logic [MUX_MAX_WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             in_valid,
`ifdef MUX_2TO1_HOLD_EN
    input  logic             en,
`endif
    output logic [WIDTH-1:0] y,
    output logic             out_valid
);
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] y_d, y_q;
    logic             valid_d, valid_q;
    logic             load;

    mux_2to1_core #(.WIDTH(WIDTH)) u_core (
        .a   (a),
        .b   (b),
        .sel (sel),
        .m   (m)
    );

`ifdef MUX_2TO1_HOLD_EN
    assign load = in_valid & en;
`else
    assign load = in_valid;
`endif

    always_comb begin
        y_d     = y_q;
        valid_d = 1'b0;
        if (load) begin
            y_d     = m;
            valid_d = 1'b1;
        end
`ifdef MUX_2TO1_HOLD_EN
        // A qualified input with the enable low freezes the whole output, valid included.
        else if (in_valid) begin
            valid_d = valid_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= RST_VAL[WIDTH-1:0];
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign y         = y_q;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_mux_2to1.sv
// tb/tb_mux_2to1.sv - scoreboard bench for mux_2to1 (1-bit and 8-bit instances)
module tb_mux_2to1;
    import mux_pkg::*;

    typedef struct {
        string      nm;
        logic       y1a;
        logic       y1b;
        logic [7:0] y8;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       sel = 1'b0;
    logic       en = 1'b1;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       y1a, y1b, v1a, v1b, v8;
    logic [7:0] y8;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;

    logic       m1a, m1b, mv;
    logic [7:0] m8;

    // {sel, a, b, expected y}
    logic [3:0] sweep_tbl [0:7] = '{4'b0000, 4'b0010, 4'b0101, 4'b0111,
                                    4'b1000, 4'b1011, 4'b1100, 4'b1111};

    always #5 clk = ~clk;

    mux_2to1 #(.WIDTH(1), .RST_VAL(64'd0)) u_w1a (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .sel(sel), .in_valid(in_valid),
`ifdef MUX_2TO1_HOLD_EN
        .en(en),
`endif
        .y(y1a), .out_valid(v1a)
    );

    mux_2to1 #(.WIDTH(1), .RST_VAL(64'd1)) u_w1b (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .sel(sel), .in_valid(in_valid),
`ifdef MUX_2TO1_HOLD_EN
        .en(en),
`endif
        .y(y1b), .out_valid(v1b)
    );

    mux_2to1 #(.WIDTH(8), .RST_VAL(64'h5A)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .sel(sel), .in_valid(in_valid),
`ifdef MUX_2TO1_HOLD_EN
        .en(en),
`endif
        .y(y8), .out_valid(v8)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what the next rising edge must produce.
    task automatic step(input string nm, input logic r, input logic iv, input logic e,
                        input logic s, input logic a1v, input logic b1v,
                        input logic [7:0] a8v, input logic [7:0] b8v,
                        input logic ex1, input logic [7:0] ex8);
        exp_t ent;
        @(negedge clk);
        rst = r; in_valid = iv; en = e; sel = s;
        a1 = a1v; b1 = b1v; a8 = a8v; b8 = b8v;
        if (r) begin
            m1a = 1'b0; m1b = 1'b1; m8 = 8'h5A; mv = 1'b0;
`ifdef MUX_2TO1_HOLD_EN
        end else if (iv && e) begin
`else
        end else if (iv) begin
`endif
            m1a = ex1; m1b = ex1; m8 = ex8; mv = 1'b1;
        end else if (!iv) begin
            mv = 1'b0;
        end
        ent.nm = nm; ent.y1a = m1a; ent.y1b = m1b; ent.y8 = m8; ent.v = mv;
        sb.push_back(ent);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({e.nm, ".y1a"}, {7'd0, y1a}, {7'd0, e.y1a});
                chk({e.nm, ".y1b"}, {7'd0, y1b}, {7'd0, e.y1b});
                chk({e.nm, ".y8"},  y8, e.y8);
                chk({e.nm, ".v1a"}, {7'd0, v1a}, {7'd0, e.v});
                chk({e.nm, ".v1b"}, {7'd0, v1b}, {7'd0, e.v});
                chk({e.nm, ".v8"},  {7'd0, v8},  {7'd0, e.v});
            end
        end
    end

    initial begin : stimulus
        m1a = 1'b0; m1b = 1'b1; m8 = 8'h5A; mv = 1'b0;

        step("reset", 1'b1, 1'b0, 1'b1, MUX_SEL_A, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00);
        step("reset_iv", 1'b1, 1'b1, 1'b1, MUX_SEL_B, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00);

        for (int i = 0; i < 8; i++) begin
            logic [3:0] t;
            t = sweep_tbl[i];
            step($sformatf("sweep%0d", i), 1'b0, 1'b1, 1'b1, t[3], t[2], t[1],
                 8'hA5, 8'h3C, t[0], t[3] ? 8'h3C : 8'hA5);
        end

        for (int i = 0; i < 6; i++) begin
            step($sformatf("toggle%0d", i), 1'b0, 1'b1, 1'b1, i[0], 1'b1, 1'b0,
                 8'hA5, 8'h3C, i[0] ? 1'b0 : 1'b1, i[0] ? 8'h3C : 8'hA5);
        end

        step("idle0", 1'b0, 1'b0, 1'b1, MUX_SEL_A, 1'b1, 1'b0, 8'h99, 8'h66, 1'b0, 8'h00);
        step("idle1", 1'b0, 1'b0, 1'b1, MUX_SEL_B, 1'b0, 1'b1, 8'h77, 8'h88, 1'b0, 8'h00);

        step("same_ab0", 1'b0, 1'b1, 1'b1, MUX_SEL_A, 1'b1, 1'b1, 8'h77, 8'h77, 1'b1, 8'h77);
        step("same_ab1", 1'b0, 1'b1, 1'b1, MUX_SEL_B, 1'b0, 1'b0, 8'h77, 8'h77, 1'b0, 8'h77);

        step("stream0", 1'b0, 1'b1, 1'b1, MUX_SEL_A, 1'b1, 1'b0, 8'h11, 8'hEE, 1'b1, 8'h11);
        step("mid_rst", 1'b1, 1'b1, 1'b1, MUX_SEL_B, 1'b0, 1'b0, 8'h22, 8'hDD, 1'b0, 8'h00);
        step("resume",  1'b0, 1'b1, 1'b1, MUX_SEL_B, 1'b0, 1'b1, 8'h33, 8'hC3, 1'b1, 8'hC3);

`ifdef MUX_2TO1_HOLD_EN
        step("en_load", 1'b0, 1'b1, 1'b1, MUX_SEL_A, 1'b0, 1'b1, 8'h11, 8'h00, 1'b0, 8'h11);
        step("en_hold0", 1'b0, 1'b1, 1'b0, MUX_SEL_A, 1'b1, 1'b0, 8'h22, 8'h00, 1'b1, 8'h22);
        step("en_hold1", 1'b0, 1'b1, 1'b0, MUX_SEL_A, 1'b1, 1'b0, 8'h22, 8'h00, 1'b1, 8'h22);
        step("en_reload", 1'b0, 1'b1, 1'b1, MUX_SEL_A, 1'b1, 1'b0, 8'h22, 8'h00, 1'b1, 8'h22);
        step("en_rst", 1'b1, 1'b1, 1'b0, MUX_SEL_A, 1'b1, 1'b0, 8'h44, 8'h00, 1'b1, 8'h44);
`endif

        step("tail_idle", 1'b0, 1'b0, 1'b1, MUX_SEL_A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
